// File: rtl/spi_pkg.sv
// Shared constants for the serial-flash read sequencer: SPI master register map,
// status/control bit positions, FSM state encoding and the header byte selector.
package spi_pkg;

  localparam logic REG_CTL  = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam int CTL_SS    = 0;
  localparam int STAT_BUSY = 7;

  localparam logic [7:0] CTL_SS_ON  = 8'(1 << CTL_SS);
  localparam logic [7:0] CTL_SS_OFF = 8'h00;

  localparam int HDR_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SS_ON,
    ST_TX,
    ST_SETTLE,
    ST_POLL,
    ST_RDATA,
    ST_HOLD,
    ST_SS_OFF
  } state_t;

  // Byte idx of the outgoing stream: opcode, address MSB first, then dummies.
  function automatic logic [7:0] tx_byte(input logic [2:0]  idx,
                                         input logic [23:0] faddr,
                                         input logic [7:0]  cmd,
                                         input logic [7:0]  dummy);
    case (idx)
      3'd0:    tx_byte = cmd;
      3'd1:    tx_byte = faddr[23:16];
      3'd2:    tx_byte = faddr[15:8];
      3'd3:    tx_byte = faddr[7:0];
      default: tx_byte = dummy;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_rd_ctrl.sv
// Serial-flash READ sequencer: drives the SPI master's two-register bus to send
// opcode + 24-bit address, then streams the received data bytes out with valid/ready.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a start with nonzero length
// ST_SS_ON  | bus write ctl = ss on
// ST_TX     | bus write tx = current header or dummy byte
// ST_SETTLE | no bus access; lets the SPI master raise its busy flag
// ST_POLL   | bus read ctl until busy clears
// ST_RDATA  | bus read rx, capture data byte
// ST_HOLD   | byte presented on stream, waiting for ready
// ST_SS_OFF | bus write ctl = ss off, done pulse visible
module spi_flash_rd_ctrl
  import spi_pkg::*;
#(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] DUMMY_TX = 8'hFF,
  parameter int         LEN_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [23:0]      i_faddr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic             o_spi_addr,
  output logic             o_spi_cs,
  output logic             o_spi_we,
  output logic [7:0]       o_spi_dat,
  input  logic [7:0]       i_spi_dat
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t           state;
  logic [23:0]      faddr_q;
  logic [LEN_W-1:0] cnt;
  logic [2:0]       idx;
  logic             abort_pend;
  logic             abort_eff;

  assign abort_eff = abort_pend | i_abort;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      faddr_q    <= '0;
      cnt        <= '0;
      idx        <= '0;
      abort_pend <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_spi_addr <= REG_CTL;
      o_spi_cs   <= 1'b0;
      o_spi_we   <= 1'b0;
      o_spi_dat  <= '0;
    end else begin
      // Bus outputs are registered for the state being entered; idle by default.
      o_spi_addr <= REG_CTL;
      o_spi_cs   <= 1'b0;
      o_spi_we   <= 1'b0;
      o_spi_dat  <= '0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;

      if (state != ST_IDLE && i_abort)
        abort_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (i_start && i_len != '0) begin
            faddr_q   <= i_faddr;
            cnt       <= i_len;
            idx       <= '0;
            o_busy    <= 1'b1;
            o_spi_cs  <= 1'b1;
            o_spi_we  <= 1'b1;
            o_spi_dat <= CTL_SS_ON;
            state     <= ST_SS_ON;
          end
        end
        ST_SS_ON: begin
          o_spi_cs   <= 1'b1;
          o_spi_we   <= 1'b1;
          o_spi_addr <= REG_DATA;
          o_spi_dat  <= tx_byte(idx, faddr_q, CMD_READ, DUMMY_TX);
          state      <= ST_TX;
        end
        ST_TX: state <= ST_SETTLE;
        ST_SETTLE: begin
          o_spi_cs <= 1'b1;
          state    <= ST_POLL;
        end
        ST_POLL: begin
          if (i_spi_dat[STAT_BUSY]) begin
            o_spi_cs <= 1'b1;
          end else if (idx < 3'(HDR_LEN)) begin
            if (abort_eff) begin
              o_spi_cs  <= 1'b1;
              o_spi_we  <= 1'b1;
              o_spi_dat <= CTL_SS_OFF;
              o_done    <= 1'b1;
              o_aborted <= 1'b1;
              state     <= ST_SS_OFF;
            end else begin
              idx        <= idx + 3'd1;
              o_spi_cs   <= 1'b1;
              o_spi_we   <= 1'b1;
              o_spi_addr <= REG_DATA;
              o_spi_dat  <= tx_byte(idx + 3'd1, faddr_q, CMD_READ, DUMMY_TX);
              state      <= ST_TX;
            end
          end else begin
            o_spi_cs   <= 1'b1;
            o_spi_addr <= REG_DATA;
            state      <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          o_rd_data  <= i_spi_dat;
          o_rd_valid <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_rd_ready) begin
            o_rd_valid <= 1'b0;
            cnt        <= cnt - CNT_ONE;
            o_spi_cs   <= 1'b1;
            o_spi_we   <= 1'b1;
            if (cnt == CNT_ONE || abort_eff) begin
              o_spi_dat <= CTL_SS_OFF;
              o_done    <= 1'b1;
              o_aborted <= abort_eff;
              state     <= ST_SS_OFF;
            end else begin
              o_spi_addr <= REG_DATA;
              o_spi_dat  <= DUMMY_TX;
              state      <= ST_TX;
            end
          end
        end
        ST_SS_OFF: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
